// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: state encoding and default parameters for the flash-to-RAM copier.
package flash_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_READY, S_REQ, S_WAIT_BUSY, S_WAIT_DONE, S_WRITE, S_DONE, S_ERROR
   } state_t;
   localparam logic [23:0] DEF_SRC_BASE = 24'h100000;
   localparam int DEF_LEN = 16384;
   localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/flash_loader.sv
// flash_loader: copies LEN bytes from flash at SRC_BASE into RAM, one busy-handshaked read per byte.
module flash_loader
   import flash_loader_pkg::*;
#(
   parameter logic [23:0] SRC_BASE = DEF_SRC_BASE,
   parameter int LEN = DEF_LEN,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        done,
   output logic        error,
   input  logic        flash_ready,
   output logic        flash_cs,
   output logic [23:0] flash_addr,
   input  logic        flash_busy,
   input  logic [7:0]  flash_dout,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_data,
   output logic        ram_we,
   input  logic        ram_wait,
   output logic [15:0] progress
);
   localparam logic [15:0] LAST = 16'(LEN - 1);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   state_t r_state, w_next;
   logic [1:0] r_sync;
   logic w_run;
   logic [15:0] r_idx, r_cnt, r_progress, r_ram_addr, w_idx_nxt;
   logic [23:0] r_faddr;
   logic [7:0] r_data;
   assign w_run = r_sync[1];
   assign w_idx_nxt = (r_state == S_WRITE) ? r_idx + 16'd1 : r_idx;
   assign flash_cs = (r_state == S_REQ) || (r_state == S_WAIT_BUSY);
   assign flash_addr = r_faddr;
   assign ram_addr = r_ram_addr;
   assign ram_data = r_data;
   assign ram_we = (r_state == S_WRITE) && !ram_wait;
   assign progress = r_progress;
   assign done = (r_state == S_DONE);
   assign error = (r_state == S_ERROR);
   // reset asserts at once but releases only after two clean edges
   always_ff @(posedge clk or posedge reset)
      if (reset) r_sync <= '0;
      else r_sync <= {r_sync[0], 1'b1};
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (w_run)
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_WAIT_READY;
            S_WAIT_READY: if (flash_ready) w_next = S_REQ;
            S_REQ: w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: w_next = flash_busy ? S_WAIT_DONE : (r_cnt == TO_LAST) ? S_ERROR : S_WAIT_BUSY;
            S_WAIT_DONE: if (!flash_busy) w_next = S_WRITE;
            S_WRITE: if (!ram_wait) w_next = (r_idx == LAST) ? S_DONE : S_REQ;
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_idx <= '0;
         r_cnt <= '0;
         r_progress <= '0;
         r_faddr <= '0;
         r_data <= '0;
         r_ram_addr <= '0;
      end else begin
         if (w_next == S_WAIT_READY && r_state != S_WAIT_READY) begin
            r_idx <= '0;
            r_progress <= '0;
         end else if (ram_we)
            r_progress <= (&r_progress) ? r_progress : r_progress + 16'd1;
         if (w_next == S_REQ) r_faddr <= SRC_BASE + {8'h00, w_idx_nxt};
         if (r_state == S_WRITE && w_next == S_REQ) r_idx <= w_idx_nxt;
         r_cnt <= (r_state == S_WAIT_BUSY) ? r_cnt + 16'd1 : '0;
         if (r_state == S_WAIT_DONE && w_next == S_WRITE) begin
            r_data <= flash_dout;
            r_ram_addr <= r_idx;
         end
      end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed checks of the flash loader with a simple busy-handshake flash model.
module tb_flash_loader;
   logic clk = 0, reset, start, start2, flash_ready, ram_wait, no_busy;
   logic done, error, flash_cs, flash_busy, ram_we;
   logic [23:0] flash_addr;
   logic [7:0] flash_dout, ram_data;
   logic [15:0] ram_addr, progress;
   logic done2, error2, flash_cs2, flash_busy2, ram_we2;
   logic [23:0] flash_addr2;
   logic [7:0] flash_dout2, ram_data2;
   logic [15:0] ram_addr2, progress2;
   int n_tests = 0, n_fail = 0;
   int wr_n = 0, cs_n = 0, cs2_n = 0, low_run = 0, min_low = 1000;
   logic [15:0] wr_addr [256];
   logic [7:0] wr_data [256];
   logic [23:0] ca [256];
   logic [23:0] ca2 [16];
   logic cs_q = 0, cs2_q = 0;
   logic [2:0] cnt = 0, cnt2 = 0;
   logic [7:0] exp_d [4] = '{8'h5A, 8'h5B, 8'h58, 8'h59};
   logic [23:0] exp_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
   int b, c, k;

   always #5 clk = ~clk;

   flash_loader #(.SRC_BASE(24'h100000), .LEN(4), .TIMEOUT(15)) u_dut (
      .clk(clk), .reset(reset), .start(start), .done(done), .error(error),
      .flash_ready(flash_ready), .flash_cs(flash_cs), .flash_addr(flash_addr),
      .flash_busy(flash_busy), .flash_dout(flash_dout), .ram_addr(ram_addr),
      .ram_data(ram_data), .ram_we(ram_we), .ram_wait(ram_wait), .progress(progress));

   flash_loader #(.SRC_BASE(24'hFFFFFE), .LEN(4), .TIMEOUT(15)) u_wrap (
      .clk(clk), .reset(reset), .start(start2), .done(done2), .error(error2),
      .flash_ready(1'b1), .flash_cs(flash_cs2), .flash_addr(flash_addr2),
      .flash_busy(flash_busy2), .flash_dout(flash_dout2), .ram_addr(ram_addr2),
      .ram_data(ram_data2), .ram_we(ram_we2), .ram_wait(1'b0), .progress(progress2));

   // flash model: busy rises two cycles after a cs rising edge and stays up for four cycles
   assign flash_busy = (cnt >= 3'd2);
   assign flash_dout = flash_addr[7:0] ^ 8'h5A;
   assign flash_busy2 = (cnt2 >= 3'd2);
   assign flash_dout2 = flash_addr2[7:0] ^ 8'h5A;

   always @(posedge clk) begin
      cs_q <= flash_cs;
      if (flash_cs && !cs_q && !no_busy) cnt <= 3'd1;
      else if (cnt != 0) cnt <= (cnt == 3'd5) ? 3'd0 : cnt + 3'd1;
      if (flash_cs && !cs_q) begin
         ca[cs_n] <= flash_addr;
         cs_n <= cs_n + 1;
         if (cs_n > 0 && low_run < min_low) min_low <= low_run;
      end
      low_run <= flash_cs ? 0 : low_run + 1;
      if (ram_we) begin
         wr_addr[wr_n] <= ram_addr;
         wr_data[wr_n] <= ram_data;
         wr_n <= wr_n + 1;
      end
      cs2_q <= flash_cs2;
      if (flash_cs2 && !cs2_q) begin
         cnt2 <= 3'd1;
         ca2[cs2_n] <= flash_addr2;
         cs2_n <= cs2_n + 1;
      end else if (cnt2 != 0) cnt2 <= (cnt2 == 3'd5) ? 3'd0 : cnt2 + 3'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_cs"}, flash_cs, 0);
      chk({tag, "_we"}, ram_we, 0);
      chk({tag, "_prog"}, progress, 0);
      chk({tag, "_faddr"}, flash_addr, 0);
      chk({tag, "_raddr"}, ram_addr, 0);
      chk({tag, "_rdata"}, ram_data, 0);
   endtask

   task automatic pulse();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 300 && !done; i++) @(negedge clk);
      chk({tag, "_done"}, done, 1);
   endtask

   task automatic check_copy(input string tag, input int base, input int cbase);
      chk({tag, "_nwr"}, wr_n - base, 4);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_ram_addr"}, wr_addr[base + i], i);
         chk({tag, "_ram_data"}, wr_data[base + i], exp_d[i]);
         chk({tag, "_flash_addr"}, ca[cbase + i], 24'h100000 + i);
      end
      chk({tag, "_progress"}, progress, 4);
      chk({tag, "_error"}, error, 0);
   endtask

   initial begin
      reset = 1; start = 0; start2 = 0; flash_ready = 1; ram_wait = 0; no_busy = 0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      // start on the very first edge after release must be swallowed by the reset synchroniser
      reset = 0;
      pulse();
      repeat (10) @(negedge clk);
      chk("sync_no_cs", cs_n, 0);
      chk("sync_done", done, 0);

      b = wr_n; c = cs_n;
      pulse();
      wait_done("basic");
      check_copy("basic", b, c);

      flash_ready = 0;
      b = wr_n; c = cs_n;
      pulse();
      repeat (50) @(negedge clk);
      chk("notready_cs_rises", cs_n - c, 0);
      chk("notready_cs", flash_cs, 0);
      chk("notready_done_clr", done, 0);
      flash_ready = 1;
      wait_done("notready");
      check_copy("notready", b, c);

      b = wr_n; c = cs_n;
      pulse();
      for (int i = 0; i < 300 && wr_n < b + 2; i++) @(negedge clk);
      ram_wait = 1;
      repeat (10) @(negedge clk);
      chk("stall_nwr", wr_n - b, 2);
      chk("stall_we", ram_we, 0);
      chk("stall_data", ram_data, 8'h58);
      chk("stall_addr", ram_addr, 2);
      ram_wait = 0;
      wait_done("stall");
      check_copy("stall", b, c);

      no_busy = 1;
      b = wr_n;
      pulse();
      for (int i = 0; i < 100 && !flash_cs; i++) @(negedge clk);
      chk("to_cs_rise", flash_cs, 1);
      k = 0;
      while (!error && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("to_latency", k, 16);
      chk("to_error", error, 1);
      chk("to_cs", flash_cs, 0);
      chk("to_done", done, 0);
      chk("to_nwr", wr_n - b, 0);
      no_busy = 0;

      b = wr_n;
      pulse();
      for (int i = 0; i < 300 && wr_n < b + 1; i++) @(negedge clk);
      for (int i = 0; i < 50 && !flash_busy; i++) @(negedge clk);
      @(negedge clk);
      #2 reset = 1;
      #1 chk_zero("midreset");
      @(negedge clk);
      reset = 0;
      repeat (5) @(negedge clk);
      chk("midreset_nwr", wr_n - b, 1);
      b = wr_n; c = cs_n;
      pulse();
      wait_done("recopy");
      check_copy("recopy", b, c);
      chk("cs_gap", min_low >= 2, 1);

      c = cs2_n;
      start2 = 1;
      @(negedge clk);
      start2 = 0;
      for (int i = 0; i < 300 && !done2; i++) @(negedge clk);
      chk("wrap_done", done2, 1);
      chk("wrap_nreq", cs2_n - c, 4);
      for (int i = 0; i < 4; i++) chk("wrap_addr", ca2[c + i], exp_a[i]);
      chk("wrap_progress", progress2, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter SRC_BASE, default 24'h100000, byte address of the first flash byte to copy.
REQ-002 Parameter LEN, default 16384, number of bytes to copy; legal range 1..65536.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles to wait for flash_busy to rise after a request.
REQ-004 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a copy; ignored unless in IDLE, DONE or ERROR.
- done  out  1  high from copy completion until the next start.
- error  out  1  high from a timeout until the next start.
- flash_ready  in  1  flash controller init finished.
- flash_cs  out  1  read request to the flash controller; the controller acts on its rising edge.
- flash_addr  out  24  byte address presented to the flash controller.
- flash_busy  in  1  flash controller transfer in progress.
- flash_dout  in  8  read byte; valid once flash_busy has fallen.
- ram_addr  out  16  destination byte offset.
- ram_data  out  8  destination byte.
- ram_we  out  1  one-cycle write strobe.
- ram_wait  in  1  RAM not able to accept a write; stalls ram_we.
- progress  out  16  count of bytes written so far.

Function
REQ-005 States: IDLE, WAIT_READY, REQ, WAIT_BUSY, WAIT_DONE, WRITE, DONE, ERROR.
REQ-006 start moves IDLE, DONE or ERROR to WAIT_READY, clears done, error and progress, and loads the index to 0.
REQ-007 WAIT_READY goes to REQ in the first cycle flash_ready is high.
REQ-008 REQ drives flash_cs=1 and flash_addr=SRC_BASE+index (24-bit, wraps modulo 2^24), clears the timeout counter, then goes to WAIT_BUSY.
REQ-009 WAIT_BUSY holds flash_cs=1 and address stable; flash_busy=1 drops flash_cs to 0 and goes to WAIT_DONE.
REQ-010 WAIT_BUSY timeout: when the counter reaches TIMEOUT without flash_busy rising, go to ERROR with flash_cs=0 and error=1.
REQ-011 WAIT_DONE: flash_busy=0 latches flash_dout into ram_data and goes to WRITE; address stays stable throughout.
REQ-012 flash_cs low time between requests is at least 2 cycles, so the controller's two-stage sync sees every rising edge.
REQ-013 WRITE: when ram_wait=0, assert ram_we for exactly one cycle with ram_addr=index[15:0] and increment progress; ram_wait=1 holds ram_we=0 and keeps ram_data and ram_addr stable.
REQ-014 After the write, if index==LEN-1 go to DONE with done=1; otherwise increment index and go to REQ.
REQ-015 Throughput is one byte per flash transaction; the loader adds at most 4 cycles of overhead per byte.
REQ-016 start during WAIT_READY..WRITE is ignored.
REQ-017 flash_ready falling mid-copy is ignored; the busy handshake alone governs.
REQ-018 LEN=65536 makes ram_addr wrap from 16'hFFFF; progress saturates at 16'hFFFF and done still asserts.

Reset
REQ-019 reset asynchronously forces IDLE and flash_cs=0, ram_we=0, done=0, error=0, progress=0, flash_addr=0, ram_addr=0, ram_data=0.
REQ-020 Reset mid-transfer abandons the byte; no ram_we is issued for it.
REQ-021 reset release is synchronised internally; the first state change occurs no earlier than the second clk edge after release.

Structure
REQ-022 Package flash_loader_pkg holds the state enumeration and the default SRC_BASE, LEN and TIMEOUT constants.
REQ-023 Single module; no sub-module.

Verification
REQ-024 LEN=4, SRC_BASE=24'h100000, flash model returns addr[7:0]^8'h5A -> writes 5A,5B,58,59 to ram_addr 0..3, then done=1 and progress=4.
REQ-025 flash_ready held low 50 cycles after start -> flash_cs stays 0 until ready; the copy then completes normally.
REQ-026 Flash model never raises busy -> error=1 exactly TIMEOUT+1 cycles after flash_cs rises, with flash_cs=0, no ram_we, and done=0.
REQ-027 ram_wait=1 for 10 cycles on byte 2 -> ram_we is delayed, ram_data stays stable, and no byte is lost or duplicated.
REQ-028 reset pulse during WAIT_DONE of byte 1 -> all outputs return to 0 at once; a new start copies from index 0.
REQ-029 SRC_BASE=24'hFFFFFE, LEN=4 -> flash_addr sequence FFFFFE, FFFFFF, 000000, 000001.
